mole_game_core: RTL

Parametrised whack-a-mole game engine that replaces the fixed 16-LED, fixed-timing game datapath with one configurable block. It sequences idle/countdown/play/game-over, places moles pseudo-randomly at a mode-dependent rate, scores hits and counts misses, and times the round internally from the system clock. Its binary outputs feed the existing B2BCD/seven-segment display path and the LED bank at the top level.

---
 rtl/mole_game_core_if.sv | 30 +++
 rtl/mole_game_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mole_game_core_if.sv
// mole_game_core_if: game control/status bundle between the
// top-level glue (master) and the game engine (slave).
interface mole_game_core_if #(
  parameter int N_MOLES = 16
);
  logic               start_i;
  logic [1:0]         mode_i;
  logic [N_MOLES-1:0] whack_i;
  logic [N_MOLES-1:0] moles_o;
  logic [1:0]         state_o;
  logic [6:0]         seconds_left_o;
  logic [13:0]        score_o;
  logic [13:0]        misses_o;
  logic               round_done_o;
  logic [13:0]        high_score_o;

  modport master (
    output start_i, mode_i, whack_i,
    input  moles_o, state_o, seconds_left_o,
    input  score_o, misses_o, round_done_o,
    input  high_score_o
  );

  modport slave (
    input  start_i, mode_i, whack_i,
    output moles_o, state_o, seconds_left_o,
    output score_o, misses_o, round_done_o,
    output high_score_o
  );
endinterface

// File: rtl/mole_game_core.sv
// mole_game_core: whack-a-mole sequencer, mole placer and scorer.
// Optional HIGH_SCORE_EN macro adds a best-score register.
module mole_game_core #(
  parameter int N_MOLES       = 16,
  parameter int ROUND_SECONDS = 30,
  parameter int TICKS_PER_SEC = 100000000
) (
  input logic clock_i,
  input logic reset_i,
  mole_game_core_if.slave bus
);
  localparam int LB   = $clog2(N_MOLES);
  localparam int HALF = TICKS_PER_SEC / 2;
  localparam int PW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CD   = 2'b01,
    PLAY = 2'b10,
    OVER = 2'b11
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic               start_prev;
  logic [N_MOLES-1:0] whack_prev;
  logic [1:0]         mode;
  logic [PW-1:0]      pre_cnt;
  logic               half_odd;
  logic [1:0]         step_cnt;
  logic [6:0]         seconds;
  logic [13:0]        score;
  logic [13:0]        misses;
  logic [N_MOLES-1:0] moles;
  logic               round_done;

  logic               go;
  logic               half_tick;
  logic               sec_tick;
  logic               enter_over;
  logic               step_due;
  logic [N_MOLES-1:0] toggles;
  logic [N_MOLES-1:0] hits;
  logic [N_MOLES-1:0] wrong;
  logic [N_MOLES-1:0] new_set;

  function automatic logic [5:0] pop(
    input logic [N_MOLES-1:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int k = 0; k < N_MOLES; k++)
      c = c + 6'(v[k]);
    return c;
  endfunction

  function automatic logic [13:0] sat_add(
    input logic [13:0] a,
    input logic [5:0]  b
  );
    logic [14:0] s;
    s = {1'b0, a} + {9'd0, b};
    return (s > 15'd9999) ? 14'd9999 : s[13:0];
  endfunction

  assign go        = bus.start_i & ~start_prev
                   & (bus.mode_i != 2'b00);
  assign half_tick = (pre_cnt == PW'(HALF - 1));
  assign sec_tick  = half_tick & half_odd;
  assign enter_over = (state == PLAY) & sec_tick
                    & (seconds == 7'd1);
  assign toggles   = bus.whack_i ^ whack_prev;
  assign hits      = toggles & moles;
  assign wrong     = toggles & ~moles;

  // Next mole set and step cadence from the latched mode.
  always_comb begin
    new_set = '0;
    new_set[lfsr[LB-1:0]] = 1'b1;
    if (mode == 2'b11)
      new_set[lfsr[2*LB-1:LB]] = 1'b1;
    case (mode)
      2'b01:   step_due = (step_cnt == 2'd3);
      2'b10:   step_due = (step_cnt == 2'd1);
      default: step_due = 1'b1;
    endcase
  end

  // Game sequencer, timebase, LFSR and scoring.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= IDLE;
      lfsr       <= 16'hACE1;
      start_prev <= bus.start_i;
      whack_prev <= bus.whack_i;
      mode       <= 2'b00;
      pre_cnt    <= '0;
      half_odd   <= 1'b0;
      step_cnt   <= 2'd0;
      seconds    <= 7'd0;
      score      <= 14'd0;
      misses     <= 14'd0;
      moles      <= '0;
      round_done <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      start_prev <= bus.start_i;
      whack_prev <= bus.whack_i;
      round_done <= 1'b0;
      if (half_tick) begin
        pre_cnt  <= '0;
        half_odd <= ~half_odd;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
      unique case (state)
        IDLE, OVER: begin
          if (go) begin
            state    <= CD;
            mode     <= bus.mode_i;
            seconds  <= 7'd3;
            score    <= 14'd0;
            misses   <= 14'd0;
            moles    <= '0;
            pre_cnt  <= '0;
            half_odd <= 1'b0;
          end
        end
        CD: begin
          if (sec_tick) begin
            if (seconds == 7'd1) begin
              state    <= PLAY;
              seconds  <= 7'(ROUND_SECONDS);
              moles    <= new_set;
              pre_cnt  <= '0;
              half_odd <= 1'b0;
              step_cnt <= 2'd0;
            end else begin
              seconds <= seconds - 7'd1;
            end
          end
        end
        PLAY: begin
          if (enter_over) begin
            state      <= OVER;
            seconds    <= 7'd0;
            moles      <= '0;
            round_done <= 1'b1;
          end else begin
            if (sec_tick)
              seconds <= seconds - 7'd1;
            score  <= sat_add(score, pop(hits));
            misses <= sat_add(misses, pop(wrong));
            if (half_tick)
              step_cnt <= step_due ? 2'd0
                                   : step_cnt + 2'd1;
            if (half_tick && step_due)
              moles <= new_set;
            else
              moles <= moles & ~hits;
          end
        end
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [13:0] high;

  // Best score since reset, captured as a round ends.
  always_ff @(posedge clock_i) begin
    if (reset_i)
      high <= 14'd0;
    else if (enter_over && score > high)
      high <= score;
  end

  assign bus.high_score_o = high;
`else
  assign bus.high_score_o = 14'd0;
`endif

  assign bus.moles_o        = moles;
  assign bus.state_o        = state;
  assign bus.seconds_left_o = seconds;
  assign bus.score_o        = score;
  assign bus.misses_o       = misses;
  assign bus.round_done_o   = round_done;
endmodule
